// File: rtl/if_stage_prefetch_pkg.sv
// Shared defaults and types for the instruction-fetch stage.
package if_pkg;
  localparam int ADDRESS_LEN_DEF = 32;
  localparam int INSTR_LEN_DEF   = 32;

  localparam logic [INSTR_LEN_DEF-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [ADDRESS_LEN_DEF-1:0] pc;
    logic [INSTR_LEN_DEF-1:0]   instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_stage_prefetch_if.sv
// Instruction memory port: request/grant issue, responses return in issue order.
interface if_stage_prefetch_if
  import if_pkg::*;
#(
  parameter int ADDRESS_LEN = ADDRESS_LEN_DEF,
  parameter int INSTR_LEN   = INSTR_LEN_DEF
);
  logic                   req;
  logic [ADDRESS_LEN-1:0] addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INSTR_LEN-1:0]   rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_stage_prefetch_fetch_fifo.sv
// Synchronous FIFO holding prefetched entries; flush wins over push and pop.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: credit-limited prefetch into an in-order queue,
// with branch redirect that flushes the queue and squashes in-flight responses.
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter int                     ADDRESS_LEN = ADDRESS_LEN_DEF,
  parameter int                     INSTR_LEN   = INSTR_LEN_DEF,
  parameter int                     FIFO_DEPTH  = 4,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0,
  parameter int                     PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_address,
  if_stage_prefetch_if.master    imem,
  output logic                   valid_out,
  output logic [INSTR_LEN-1:0]   instruction_out,
  output logic [ADDRESS_LEN-1:0] pc_out
);
  localparam int                     CW   = $clog2(FIFO_DEPTH + 1);
  localparam int                     SW   = CW + 1;
  localparam logic [ADDRESS_LEN-1:0] STEP = ADDRESS_LEN'(PC_STEP);

  typedef struct packed {
    logic [ADDRESS_LEN-1:0] pc;
    logic [INSTR_LEN-1:0]   instr;
  } entry_t;

  logic [ADDRESS_LEN-1:0] fetch_pc;
  logic [ADDRESS_LEN-1:0] resp_pc;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          inflight_nxt;
  logic [CW-1:0]          discard;
  logic [CW-1:0]          count;
  logic                   credit_ok;
  logic                   issue;
  logic                   resp_keep;
  logic                   pop;
  entry_t                 head;
  entry_t                 push_data;

  // Queued plus outstanding entries never exceed the queue size, so it cannot overflow.
  assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < SW'(FIFO_DEPTH);
  assign imem.req  = rst && credit_ok;
  assign imem.addr = fetch_pc;

  assign issue        = imem.req && imem.gnt;
  assign inflight_nxt = inflight + CW'(issue) - CW'(imem.rvalid);
  assign resp_keep    = imem.rvalid && (discard == '0) && !branch_taken;
  assign push_data    = '{pc: resp_pc, instr: imem.rdata};

  assign valid_out       = (count != '0);
  assign pop             = valid_out && !freeze;
  assign instruction_out = valid_out ? head.instr : INSTR_LEN'(NOP_INSTR);
  assign pc_out          = valid_out ? head.pc + STEP : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (branch_taken) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= branch_address;
        resp_pc  <= branch_address;
        discard  <= inflight_nxt;
      end else begin
        if (issue)            fetch_pc <= fetch_pc + STEP;
        if (resp_keep)        resp_pc  <= resp_pc + STEP;
        else if (imem.rvalid) discard  <= discard - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data (push_data),
    .pop       (pop),
    .flush     (branch_taken),
    .head      (head),
    .count     (count)
  );

  a_rvalid_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
    !(imem.rvalid && inflight == '0))
    else $error("response received with no request outstanding");

  a_inflight_bounded: assert property (@(posedge clk) disable iff (!rst)
    inflight <= CW'(FIFO_DEPTH))
    else $error("outstanding request count above queue depth");
endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch: memory model with configurable latency,
// scoreboard of expected {pc_out, instruction} checked by a forked monitor.
module tb_if_stage_prefetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;
  int issue_total = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  pend_t pend[$];
  exp_t  sb[$];

  if_stage_prefetch_if imem ();

  always #5 clk = ~clk;

  if_stage_prefetch #(
    .ADDRESS_LEN (32),
    .INSTR_LEN   (32),
    .FIFO_DEPTH  (4),
    .RESET_PC    (32'h0),
    .PC_STEP     (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .imem            (imem),
    .valid_out       (valid_out),
    .instruction_out (instruction_out),
    .pc_out          (pc_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  // Memory: records issues mid-cycle and returns each response lat cycles later, in order.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pend.delete();
      imem.rvalid = 1'b0;
      imem.rdata  = '0;
    end else begin
      if (imem.req && imem.gnt) begin
        pend.push_back('{imem.addr, cyc + lat});
        issue_total++;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr);
    sb.push_back('{pc, instr});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && valid_out && !freeze) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got pc_out 0x%08h instr 0x%08h, expected nothing",
                   pc_out, instruction_out);
        end else begin
          e = sb.pop_front();
          check("sb_pc_out", pc_out, e.pc);
          check("sb_instr", instruction_out, e.instr);
        end
      end else if (rst && !valid_out) begin
        check("idle_pc_out", pc_out, 32'h0);
        check("idle_instr", instruction_out, 32'h0);
      end
    end
  endtask

  initial begin
    int base;
    fork
      run_monitor();
    join_none
    imem.gnt = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(imem.req), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr", instruction_out, 32'h0);

    // 1: single-cycle memory, 8 sequential fetches
    tick(); rst = 1'b1; imem.gnt = 1'b1; lat = 1;
    for (int i = 1; i <= 8; i++) expect_out(32'(4 * i), mem_word(32'(4 * (i - 1))));
    @(negedge clk);
    check("t1_req", 32'(imem.req), 32'd1);
    check("t1_addr0", imem.addr, 32'h0);
    check("t1_valid_c0", 32'(valid_out), 32'd0);
    tick();
    @(negedge clk);
    check("t1_addr1", imem.addr, 32'h4);
    check("t1_valid_c1", 32'(valid_out), 32'd0);
    tick();
    @(negedge clk);
    check("t1_valid_c2", 32'(valid_out), 32'd1);
    repeat (6) tick();
    imem.gnt = 1'b0;
    repeat (8) tick();
    check("t1_drained", 32'(sb.size()), 32'd0);

    // 2: freeze for 6 cycles, credits cap issue at 4, head held
    base = issue_total;
    freeze = 1'b1; imem.gnt = 1'b1;
    for (int i = 0; i < 4; i++) expect_out(32'(36 + 4 * i), mem_word(32'(32 + 4 * i)));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("t2_hold_valid", 32'(valid_out), 32'd1);
        check("t2_hold_pc", pc_out, 32'd36);
        check("t2_hold_instr", instruction_out, mem_word(32'd32));
      end
      if (i == 5) check("t2_req_blocked", 32'(imem.req), 32'd0);
      tick();
    end
    check("t2_issued", 32'(issue_total - base), 32'd4);
    freeze = 1'b0; imem.gnt = 1'b0;
    repeat (8) tick();
    check("t2_drained", 32'(sb.size()), 32'd0);

    // 3: latency 3, two stale requests in flight at the branch
    lat = 3; imem.gnt = 1'b1;
    expect_out(32'h104, mem_word(32'h100));
    expect_out(32'h108, mem_word(32'h104));
    tick();
    tick(); imem.gnt = 1'b0; branch_taken = 1'b1; branch_address = 32'h100;
    tick(); branch_taken = 1'b0; imem.gnt = 1'b1;
    @(negedge clk);
    check("t3_flushed", 32'(valid_out), 32'd0);
    check("t3_req", 32'(imem.req), 32'd1);
    check("t3_addr", imem.addr, 32'h100);
    tick();
    tick(); imem.gnt = 1'b0;
    repeat (8) tick();
    check("t3_drained", 32'(sb.size()), 32'd0);

    // 4: branch coincides with a grant and a response
    lat = 1; imem.gnt = 1'b1;
    expect_out(32'h10C, mem_word(32'h108));
    expect_out(32'h110, mem_word(32'h10C));
    expect_out(32'h204, mem_word(32'h200));
    expect_out(32'h208, mem_word(32'h204));
    tick();
    tick();
    tick(); branch_taken = 1'b1; branch_address = 32'h200;
    @(negedge clk);
    check("t4_req_in_branch", 32'(imem.req), 32'd1);
    tick(); branch_taken = 1'b0;
    @(negedge clk);
    check("t4_flushed", 32'(valid_out), 32'd0);
    check("t4_addr", imem.addr, 32'h200);
    tick();
    tick(); imem.gnt = 1'b0;
    repeat (8) tick();
    check("t4_drained", 32'(sb.size()), 32'd0);

    // 5: address wrap at the top of the address space
    branch_taken = 1'b1; branch_address = 32'hFFFF_FFF8;
    expect_out(32'hFFFF_FFFC, mem_word(32'hFFFF_FFF8));
    expect_out(32'h0000_0000, mem_word(32'hFFFF_FFFC));
    expect_out(32'h0000_0004, mem_word(32'h0000_0000));
    tick(); branch_taken = 1'b0; imem.gnt = 1'b1;
    @(negedge clk);
    check("t5_addr_a", imem.addr, 32'hFFFF_FFF8);
    tick();
    @(negedge clk);
    check("t5_addr_b", imem.addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("t5_wrap", imem.addr, 32'h0000_0000);
    tick(); imem.gnt = 1'b0;
    repeat (8) tick();
    check("t5_drained", 32'(sb.size()), 32'd0);

    // 6: reset with three requests outstanding and one entry queued
    lat = 3; imem.gnt = 1'b1;
    repeat (4) tick();
    check("t6_pre_valid", 32'(valid_out), 32'd1);
    rst = 1'b0; imem.gnt = 1'b0;
    #1;
    check("t6_rst_req", 32'(imem.req), 32'd0);
    check("t6_rst_valid", 32'(valid_out), 32'd0);
    check("t6_rst_pc_out", pc_out, 32'h0);
    check("t6_rst_instr", instruction_out, 32'h0);
    tick();
    tick(); rst = 1'b1; lat = 1; imem.gnt = 1'b1;
    expect_out(32'h4, mem_word(32'h0));
    expect_out(32'h8, mem_word(32'h4));
    @(negedge clk);
    check("t6_restart_addr", imem.addr, 32'h0);
    tick();
    tick(); imem.gnt = 1'b0;
    repeat (8) tick();
    check("t6_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
